// File: rtl/program_counter_rs_if.sv
// ----------------------------------------------------------------------------
// program_counter_rs_if
// Purpose : Bundles the fetch-stage control inputs and the program-counter /
//           return-stack status outputs of program_counter_rs.
// Signals (named from the program counter's point of view):
//   i_stall        1 = freeze all program-counter state this cycle
//   i_op           3-bit operation select (HOLD/INC/REL/ABS/CALL/RET)
//   i_offset       signed relative-branch displacement
//   i_target       absolute jump/call destination
//   o_pc           current program counter (registered)
//   o_return_addr  top of return stack, 0 when the stack is empty
//   o_depth        number of valid return-stack entries (registered)
//   o_overflow     sticky: CALL attempted with the stack full
//   o_underflow    sticky: RET attempted with the stack empty
// Modports: master = fetch controller, slave = program counter.
// ----------------------------------------------------------------------------
interface program_counter_rs_if #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned OFF_WIDTH   = 8,
    parameter int unsigned STACK_DEPTH = 8
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                 i_stall;
    logic [2:0]           i_op;
    logic [OFF_WIDTH-1:0] i_offset;
    logic [WIDTH-1:0]     i_target;
    logic [WIDTH-1:0]     o_pc;
    logic [WIDTH-1:0]     o_return_addr;
    logic [DEPTH_W-1:0]   o_depth;
    logic                 o_overflow;
    logic                 o_underflow;

    modport master (
        output i_stall, i_op, i_offset, i_target,
        input  o_pc, o_return_addr, o_depth, o_overflow, o_underflow
    );

    modport slave (
        input  i_stall, i_op, i_offset, i_target,
        output o_pc, o_return_addr, o_depth, o_overflow, o_underflow
    );
endinterface

// File: rtl/program_counter_rs.sv
// ----------------------------------------------------------------------------
// program_counter_rs
// Purpose : Fetch-stage program counter with an integrated return-address
//           stack. Per cycle: hold, increment, relative branch, absolute
//           jump, call (push PC+1, jump) or return (pop, jump). Stall freezes
//           everything; overflow/underflow flags are sticky until reset.
// Ports:
//   i_clk    rising-edge clock
//   i_reset  synchronous, active-high reset (priority over stall and op)
//   bus      program_counter_rs_if slave modport (control in, status out)
// ----------------------------------------------------------------------------
module program_counter_rs #(
    parameter int unsigned      WIDTH        = 16,
    parameter int unsigned      OFF_WIDTH    = 8,
    parameter int unsigned      STACK_DEPTH  = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic                 i_clk,
    input logic                 i_reset,
    program_counter_rs_if.slave bus
);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PTR_W   = $clog2(STACK_DEPTH);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_REL  = 3'b010;
    localparam logic [2:0] OP_ABS  = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;

    logic [WIDTH-1:0]   r_pc;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_overflow;
    logic               r_underflow;
    // Entries are not reset; r_depth alone says which ones are valid.
    logic [WIDTH-1:0]   r_stack [STACK_DEPTH];

    logic [WIDTH-1:0]   w_off_ext;
    logic [WIDTH-1:0]   w_pc_inc;
    logic               w_full;
    logic               w_empty;
    logic [PTR_W-1:0]   w_push_idx;
    logic [PTR_W-1:0]   w_top_idx;
    logic [WIDTH-1:0]   w_pc_next;
    logic [DEPTH_W-1:0] w_depth_next;
    logic               w_push;
    logic               w_set_ovf;
    logic               w_set_unf;

    // Size cast of a signed value sign-extends the displacement.
    assign w_off_ext  = WIDTH'($signed(bus.i_offset));
    assign w_pc_inc   = r_pc + WIDTH'(1);
    assign w_full     = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign w_empty    = (r_depth == '0);
    // Only meaningful when not full / not empty respectively.
    assign w_push_idx = PTR_W'(r_depth);
    assign w_top_idx  = PTR_W'(r_depth - DEPTH_W'(1));

    always_comb begin
        w_pc_next    = r_pc;
        w_depth_next = r_depth;
        w_push       = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        unique case (bus.i_op)
            OP_HOLD: ;
            OP_INC:  w_pc_next = w_pc_inc;
            OP_REL:  w_pc_next = r_pc + w_off_ext;
            OP_ABS:  w_pc_next = bus.i_target;
            OP_CALL: begin
                if (w_full) begin
                    w_set_ovf = 1'b1;
                end else begin
                    w_push       = 1'b1;
                    w_pc_next    = bus.i_target;
                    w_depth_next = r_depth + DEPTH_W'(1);
                end
            end
            OP_RET: begin
                if (w_empty) begin
                    w_set_unf = 1'b1;
                end else begin
                    w_pc_next    = r_stack[w_top_idx];
                    w_depth_next = r_depth - DEPTH_W'(1);
                end
            end
            default: ;  // reserved encodings behave as HOLD
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc        <= RESET_VECTOR;
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!bus.i_stall) begin
            r_pc        <= w_pc_next;
            r_depth     <= w_depth_next;
            r_overflow  <= r_overflow | w_set_ovf;
            r_underflow <= r_underflow | w_set_unf;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && !bus.i_stall && w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign bus.o_pc          = r_pc;
    assign bus.o_depth       = r_depth;
    assign bus.o_overflow    = r_overflow;
    assign bus.o_underflow   = r_underflow;
    assign bus.o_return_addr = w_empty ? '0 : r_stack[w_top_idx];
endmodule

// File: doc/program_counter_rs.md
# program_counter_rs

Parametrised program counter with an integrated return-address stack for the 3710 processor's fetch stage. Each cycle it holds, increments, branches relative (signed offset), jumps absolute, calls (push return address, jump) or returns (pop, jump), with stall support and sticky stack overflow/underflow flags. It drives the instruction-memory address directly and replaces the fixed 16-bit unsigned-increment counter.

## Interface
- WIDTH, 16, PC and target address width
- OFF_WIDTH, 8, signed relative-branch offset width (OFF_WIDTH <= WIDTH)
- STACK_DEPTH, 8, return-stack entries (power of 2, >= 2)
- RESET_VECTOR, 0, PC value after reset
- Clock  input  1  rising-edge clock; one clock domain
- Reset  input  1  synchronous, active-high; sampled on rising edge of Clock
- Stall  input  1  1 = freeze all state this cycle
- Op  input  3  operation select (encoding below)
- Offset  input  OFF_WIDTH  signed two's-complement branch displacement
- Target  input  WIDTH  absolute jump/call destination
- PC  output  WIDTH  current program counter (registered)
- ReturnAddr  output  WIDTH  combinational top-of-stack; 0 when Depth == 0
- Depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries (registered)
- Overflow  output  1  sticky: CALL attempted with stack full
- Underflow  output  1  sticky: RET attempted with stack empty

## Operation
- Op encoding: 000 HOLD, 001 INC, 010 REL, 011 ABS, 100 CALL, 101 RET, 110/111 reserved (behave as HOLD, no flag).
- HOLD: PC unchanged.
- INC: PC <= PC + 1.
- REL: PC <= PC + sign_extend(Offset); Offset is relative to the current PC (not PC+1).
- ABS: PC <= Target.
- CALL, Depth < STACK_DEPTH: stack[Depth] <= PC + 1, Depth <= Depth + 1, PC <= Target.
- CALL, Depth == STACK_DEPTH: PC, stack, Depth unchanged; Overflow <= 1.
- RET, Depth > 0: PC <= stack[Depth-1], Depth <= Depth - 1.
- RET, Depth == 0: PC, Depth unchanged; Underflow <= 1.
- All PC arithmetic modulo 2^WIDTH: increment, REL and CALL return address wrap silently (0xFFFF + 1 = 0x0000 at WIDTH 16).
- Stall == 1: every register holds, including flags; Op ignored.
- Priority: Reset > Stall > Op.
- Overflow/Underflow cleared only by Reset; never cleared by later successful operations.
- Stack entries not required to be cleared on reset; only Depth resets. ReturnAddr must read 0 whenever Depth == 0 regardless of stale contents.

## Timing
- Reset values (first edge with Reset = 1): PC = RESET_VECTOR, Depth = 0, Overflow = 0, Underflow = 0, ReturnAddr = 0.
- Reset asserted mid-sequence (e.g. stack partly full) takes effect at that edge; Op and Stall ignored that cycle.
- Latency: Op/Offset/Target sampled at rising edge N; new PC, Depth, flags visible after edge N. One operation per cycle, back-to-back with no bubbles.
- CALL followed immediately by RET returns to the pushed PC+1 on the next edge.
- ReturnAddr changes combinationally with Depth/stack contents, same cycle as Depth.
- No combinational path from any input to PC, Depth or flags.

## Test plan
- Reset then 3× INC (WIDTH 16, RESET_VECTOR 0x0000) -> PC 0x0001, 0x0002, 0x0003; Depth 0; flags 0.
- PC 0x0010, REL Offset 0xFE (−2) -> PC 0x000E; then REL 0x7F -> PC 0x008D; PC 0xFFFF INC -> 0x0000.
- PC 0x0020, CALL Target 0x0100 -> PC 0x0100, Depth 1, ReturnAddr 0x0021; RET -> PC 0x0021, Depth 0, ReturnAddr 0.
- STACK_DEPTH 4: five nested CALLs -> Depth 4 after fourth, fifth leaves PC at fourth target, Overflow 1; four RETs unwind in LIFO order; fifth RET -> PC unchanged, Underflow 1; Overflow still 1.
- Stall 1 with Op CALL for 3 cycles -> PC, Depth, flags unchanged; Stall drops -> CALL executes on next edge.
- Depth 2 with Overflow set, assert Reset with Op RET -> PC RESET_VECTOR, Depth 0, both flags 0; reserved Op 110 afterwards -> PC holds.
